// File: rtl/text_buffer_ctrl_if.sv
// Write-requester, control and renderer-read signals of the double-buffered text store.
// The master side is the requesters, the frame timing and the renderer; the slave side is the store.
interface text_buffer_ctrl_if #(
    parameter int IDX_W  = 3,
    parameter int CODE_W = 8
);
    logic              frame_start;
    logic              clr_req;
    logic              req0_valid;
    logic [IDX_W-1:0]  req0_idx;
    logic [CODE_W-1:0] req0_code;
    logic              req0_ready;
    logic              req1_valid;
    logic [IDX_W-1:0]  req1_idx;
    logic [CODE_W-1:0] req1_code;
    logic              req1_ready;
    logic [IDX_W-1:0]  rd_idx;
    logic [CODE_W-1:0] rd_code;
    logic              busy;
    logic              swapped;
    logic              wr_drop;

    modport master (
        output frame_start, clr_req,
        output req0_valid, req0_idx, req0_code,
        output req1_valid, req1_idx, req1_code, rd_idx,
        input  req0_ready, req1_ready, rd_code, busy, swapped, wr_drop
    );

    modport slave (
        input  frame_start, clr_req,
        input  req0_valid, req0_idx, req0_code,
        input  req1_valid, req1_idx, req1_code, rd_idx,
        output req0_ready, req1_ready, rd_code, busy, swapped, wr_drop
    );
endinterface

// File: rtl/text_buffer_ctrl.sv
// Double-buffered character-cell store: two arbitrated writers fill the back bank, and the
// banks swap only on frame_start. Every swap is followed by a copy from front to back.
module text_buffer_ctrl #(
    parameter int CELLS      = 7,
    parameter int CODE_W     = 8,
    parameter int IDX_W      = 3,
    parameter int BLANK_CODE = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    text_buffer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COPY, CLEAR} state_e;

    localparam logic [CODE_W-1:0] BLANK  = CODE_W'(BLANK_CODE);
    localparam logic [IDX_W-1:0]  LAST   = IDX_W'(CELLS - 1);
    localparam logic [IDX_W:0]    NCELLS = (IDX_W + 1)'(CELLS);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              front_q, front_d;
    logic              swp_q, swp_d;
    logic              clrp_q, clrp_d;
    logic              last_q, last_d;
    logic              swapped_q, swapped_d;
    logic              drop_q, drop_d;
    logic [CODE_W-1:0] bank_q [2][CELLS];

    logic              g0, g1, we;
    logic [IDX_W-1:0]  x_idx, we_idx;
    logic [CODE_W-1:0] x_code, we_data;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        front_d   = front_q;
        swp_d     = swp_q;
        clrp_d    = clrp_q | bus.clr_req;
        last_d    = last_q;
        swapped_d = 1'b0;
        drop_d    = 1'b0;
        g0        = 1'b0;
        g1        = 1'b0;
        we        = 1'b0;
        we_idx    = cnt_q;
        we_data   = BLANK;
        x_idx     = bus.req0_idx;
        x_code    = bus.req0_code;
        unique case (state_q)
            IDLE: begin
                if (bus.frame_start && swp_q) begin
                    front_d   = ~front_q;
                    swp_d     = 1'b0;
                    swapped_d = 1'b1;
                    state_d   = COPY;
                    cnt_d     = '0;
                end else if (bus.clr_req || clrp_q) begin
                    clrp_d  = 1'b0;
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    // On a tie, the requester that did not win last time gets the grant.
                    g0 = bus.req0_valid && (!bus.req1_valid || last_q);
                    g1 = bus.req1_valid && (!bus.req0_valid || !last_q);
                    if (g1) begin
                        x_idx  = bus.req1_idx;
                        x_code = bus.req1_code;
                    end
                    if (g0 || g1) begin
                        last_d = g1;
                        if ({1'b0, x_idx} < NCELLS) begin
                            we      = 1'b1;
                            we_idx  = x_idx;
                            we_data = x_code;
                            swp_d   = 1'b1;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                end
            end
            COPY: begin
                // front_q already points at the new front, so the back bank resyncs to it.
                we      = 1'b1;
                we_data = bank_q[front_q][cnt_q];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = IDLE;
            end
            CLEAR: begin
                we    = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    swp_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            front_q   <= 1'b0;
            swp_q     <= 1'b0;
            clrp_q    <= 1'b0;
            last_q    <= 1'b1;
            swapped_q <= 1'b0;
            drop_q    <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < CELLS; c++)
                    bank_q[b][c] <= BLANK;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            front_q   <= front_d;
            swp_q     <= swp_d;
            clrp_q    <= clrp_d;
            last_q    <= last_d;
            swapped_q <= swapped_d;
            drop_q    <= drop_d;
            if (we) bank_q[~front_q][we_idx] <= we_data;
        end
    end

    assign bus.req0_ready = g0 & rst_n;
    assign bus.req1_ready = g1 & rst_n;
    assign bus.busy       = (state_q != IDLE);
    assign bus.swapped    = swapped_q;
    assign bus.wr_drop    = drop_q;
    assign bus.rd_code    = ({1'b0, bus.rd_idx} < NCELLS) ? bank_q[front_q][bus.rd_idx] : BLANK;
endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
- Double-buffered character-cell store that feeds the on-screen text renderer (glyph decode + pixel mux) with one character code per cell.
- Two write requesters share the store under round-robin arbitration; the game/control FSM and the input handler are typical requesters.
- Writes land in a back bank and become visible only on a frame boundary, so a text update never tears mid-frame.
- The block sequences bank swaps, back-bank resync after swap, and bulk clears.

Parameters:
- CELLS, 7, number of character cells on the text line
- CODE_W, 8, character code width
- IDX_W, 3, cell index width; must satisfy 2**IDX_W >= CELLS
- BLANK_CODE, 36, code written by reset and by clear (blank glyph)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- req0_valid  in  1  requester 0 write valid
- req0_idx  in  IDX_W  requester 0 cell index
- req0_code  in  CODE_W  requester 0 character code
- req0_ready  out  1  requester 0 write accepted this cycle
- req1_valid, req1_idx, req1_code, req1_ready  same as requester 0
- clr_req  in  1  one-cycle pulse: blank all cells
- rd_idx  in  IDX_W  renderer cell select
- rd_code  out  CODE_W  front-bank code at rd_idx (combinational)
- busy  out  1  CLEAR or COPY in progress
- swapped  out  1  one-cycle pulse: front bank toggled
- wr_drop  out  1  one-cycle pulse: accepted write had idx >= CELLS

Behaviour:
- Storage: two banks of CELLS x CODE_W registers; front_sel picks the displayed bank. rd_code = front[rd_idx]; it returns BLANK_CODE when rd_idx >= CELLS.
- Reset (async, rst_n=0):
  - both banks = BLANK_CODE; front_sel = 0; state = IDLE
  - swap_pending = 0, clr_pending = 0, last_grant = 1 (requester 0 wins first tie)
  - busy = 0, swapped = 0, wr_drop = 0, req*_ready = 0
  - Reset mid-CLEAR/COPY aborts immediately to this state.
- States:
  - IDLE: accepts writes; services events in the priority order below.
  - COPY: cnt runs 0..CELLS-1; each cycle back[cnt] <= front[cnt]; after the last cell go to IDLE.
  - CLEAR: cnt runs 0..CELLS-1; each cycle back[cnt] <= BLANK_CODE; on the last cell set swap_pending and go to IDLE.
- IDLE priority, evaluated each cycle:
  1. frame_start && swap_pending: toggle front_sel, clear swap_pending, pulse swapped next cycle, enter COPY with cnt=0.
  2. else clr_req || clr_pending: clear clr_pending, enter CLEAR with cnt=0.
  3. else arbitration: no ready asserted in cycles where 1 or 2 fires.
- Arbitration (IDLE only):
  - Single valid requester: that requester is granted.
  - Both valid: grant the one != last_grant.
  - reqK_ready = grant_K; ready is combinational on valid. At most one ready per cycle.
  - Transfer on valid && ready: back[idx] <= code, last_grant <= K, swap_pending <= 1.
  - idx >= CELLS: still accepted (ready=1), no write, swap_pending unchanged, wr_drop pulses next cycle.
- Outside IDLE: both ready = 0. Requesters hold valid/idx/code stable until ready.
- clr_req during COPY or CLEAR sets clr_pending; it is serviced on return to IDLE.
- frame_start outside IDLE, or with swap_pending=0, is ignored. Any pending swap waits for the next frame_start.
- busy = (state != IDLE), registered with the state.
- Latency:
  - accepted write to rd_code change: the cycle after the next serviced frame_start
  - swap + resync: busy for exactly CELLS cycles
  - clear: CELLS cycles of busy, visible after the following frame_start

Test Plan:
- Reset, then rd_idx 0..6 -> rd_code = 36 for all; busy=0; ready=0 with no valids; rd_idx=7 -> 36.
- req0 writes idx2 code 21, no frame_start for 100 cycles -> rd_code[2] stays 36. Pulse frame_start -> swapped pulse, rd_code[2]=21 the next cycle, busy high for 7 cycles, then the back bank matches the front (next write to idx3 only leaves idx2=21 after swap).
- req0 and req1 valid continuously from reset (different idx) -> grants alternate 0,1,0,1; never both ready in one cycle; all four writes land after frame_start.
- Pulse clr_req during COPY -> CLEAR starts the cycle after COPY ends; after a further frame_start all rd_code = 36.
- Write with idx=7 -> ready=1, wr_drop pulse, swap_pending stays 0; the next frame_start produces no swapped pulse.
- Assert rst_n=0 mid-CLEAR (cnt=3) -> busy=0 and both banks = 36 immediately; after release, first tie grants requester 0.
